// File: rtl/lcd1602_responder.sv
// lcd1602_responder: HD44780-style LCD1602 bus responder (DDRAM, address counter, busy model).
// Define LCD1602_READ_EN to enable host instruction/data reads; the default build is write-only.
module lcd1602_responder #(
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 82000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_e,
  input  logic [7:0] lcd_db_in,
  output logic [7:0] lcd_db_out,
  output logic       lcd_db_oe,
  input  logic [6:0] ram_rd_addr,
  output logic [7:0] ram_rd_data,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       busy,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic       err
);

  localparam int CW = $clog2(CLEAR_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_BUSY
  } state_t;

  // DDRAM is two 40-byte lines at 0x00-0x27 and 0x40-0x67.
  function automatic logic addr_ok(input logic [6:0] a);
    return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
  endfunction

  function automatic logic [6:0] ac_inc(input logic [6:0] a);
    if (a == 7'h27) return 7'h40;
    if (a == 7'h67) return 7'h00;
    return a + 7'd1;
  endfunction

  function automatic logic [6:0] ac_dec(input logic [6:0] a);
    if (a == 7'h40) return 7'h27;
    if (a == 7'h00) return 7'h67;
    return a - 7'd1;
  endfunction

  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    return inc ? ac_inc(a) : ac_dec(a);
  endfunction

  function automatic logic [6:0] ram_idx(input logic [6:0] a);
    return a[6] ? ({1'b0, a[5:0]} + 7'd40) : a;
  endfunction

  // Bus synchronizers; e_q holds the previous synchronized E for edge detection.
  logic       e_s1, e_s2, e_q;
  logic       rs_s1, rs_s2;
  logic       rw_s1, rw_s2;
  logic [7:0] db_s1, db_s2;
  logic       strobe;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      e_s1  <= 1'b0;
      e_s2  <= 1'b0;
      e_q   <= 1'b0;
      rs_s1 <= 1'b0;
      rs_s2 <= 1'b0;
      rw_s1 <= 1'b0;
      rw_s2 <= 1'b0;
      db_s1 <= 8'h00;
      db_s2 <= 8'h00;
    end else begin
      e_s1  <= lcd_e;
      e_s2  <= e_s1;
      e_q   <= e_s2;
      rs_s1 <= lcd_rs;
      rs_s2 <= rs_s1;
      rw_s1 <= lcd_rw;
      rw_s2 <= rw_s1;
      db_s1 <= lcd_db_in;
      db_s2 <= db_s1;
    end
  end

  assign strobe = e_q & ~e_s2;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    fill_q, fill_d;
  logic [6:0]    ac_q, ac_d;
  logic          id_q, id_d;
  logic          sh_q, sh_d;
  logic          disp_q, disp_d;
  logic          cur_q, cur_d;
  logic          blk_q, blk_d;
  logic          cgram_q, cgram_d;
  logic [4:0]    func_q, func_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic [7:0]    cmd_code_q, cmd_code_d;
  logic          err_q, err_d;
  logic          mem_we;
  logic [6:0]    mem_wa;
  logic [7:0]    mem_wd;
  logic          accept, go_fill, load_home;

  logic [7:0] ddram [80];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fill_d      = fill_q;
    ac_d        = ac_q;
    id_d        = id_q;
    sh_d        = sh_q;
    disp_d      = disp_q;
    cur_d       = cur_q;
    blk_d       = blk_q;
    cgram_d     = cgram_q;
    func_d      = func_q;
    cmd_valid_d = 1'b0;
    cmd_code_d  = cmd_code_q;
    err_d       = 1'b0;
    mem_we      = 1'b0;
    mem_wa      = ac_q;
    mem_wd      = db_s2;
    accept      = 1'b0;
    go_fill     = 1'b0;
    load_home   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (strobe && !rw_s2 && !rs_s2) begin
          casez (db_s2)
            8'b1???_????: begin
              if (addr_ok(db_s2[6:0])) begin
                ac_d    = db_s2[6:0];
                cgram_d = 1'b0;
                accept  = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end
            8'b01??_????: begin
              cgram_d = 1'b1;
              accept  = 1'b1;
            end
            8'b001?_????: begin
              func_d = db_s2[4:0];
              accept = 1'b1;
            end
            8'b0001_????: begin
              if (!db_s2[3]) ac_d = ac_step(ac_q, db_s2[2]);
              accept = 1'b1;
            end
            8'b0000_1???: begin
              disp_d = db_s2[2];
              cur_d  = db_s2[1];
              blk_d  = db_s2[0];
              accept = 1'b1;
            end
            8'b0000_01??: begin
              id_d   = db_s2[1];
              sh_d   = db_s2[0];
              accept = 1'b1;
            end
            8'b0000_001?: begin
              ac_d      = 7'h00;
              load_home = 1'b1;
              accept    = 1'b1;
            end
            8'b0000_0001: begin
              ac_d    = 7'h00;
              id_d    = 1'b1;
              go_fill = 1'b1;
              accept  = 1'b1;
            end
            default: ;
          endcase
        end else if (strobe && !rw_s2 && rs_s2) begin
          // A data write in CGRAM mode still occupies the controller but touches nothing.
          if (!cgram_q) begin
            mem_we = 1'b1;
            ac_d   = ac_step(ac_q, id_q);
          end
          state_d = ST_BUSY;
          cnt_d   = CW'(BUSY_CYCLES);
        end
`ifdef LCD1602_READ_EN
        else if (strobe && rw_s2 && rs_s2) begin
          ac_d = ac_step(ac_q, id_q);
        end
`endif
        if (accept) begin
          cmd_valid_d = 1'b1;
          cmd_code_d  = db_s2;
          fill_d      = 7'h00;
          state_d     = go_fill ? ST_FILL : ST_BUSY;
          cnt_d       = load_home ? CW'(CLEAR_CYCLES) : CW'(BUSY_CYCLES);
        end
      end
      ST_FILL: begin
        mem_we = 1'b1;
        mem_wa = fill_q;
        mem_wd = 8'h20;
        if (fill_q == 7'h67) begin
          state_d = ST_BUSY;
          cnt_d   = CW'(CLEAR_CYCLES - 80);
        end else begin
          fill_d = ac_inc(fill_q);
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef LCD1602_READ_EN
    if (strobe && (state_q != ST_IDLE) && (!rw_s2 || rs_s2)) err_d = 1'b1;
`else
    if (strobe && (state_q != ST_IDLE) && !rw_s2) err_d = 1'b1;
`endif
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      fill_q      <= 7'h00;
      ac_q        <= 7'h00;
      id_q        <= 1'b1;
      sh_q        <= 1'b0;
      disp_q      <= 1'b0;
      cur_q       <= 1'b0;
      blk_q       <= 1'b0;
      cgram_q     <= 1'b0;
      func_q      <= 5'h00;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= 8'h00;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fill_q      <= fill_d;
      ac_q        <= ac_d;
      id_q        <= id_d;
      sh_q        <= sh_d;
      disp_q      <= disp_d;
      cur_q       <= cur_d;
      blk_q       <= blk_d;
      cgram_q     <= cgram_d;
      func_q      <= func_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      err_q       <= err_d;
    end
  end

  // NOTE: the DDRAM array has no reset; a reset mid-clear leaves partial contents.
  always_ff @(posedge Clk) begin
    if (mem_we) ddram[ram_idx(mem_wa)] <= mem_wd;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) ram_rd_data <= 8'h00;
    else     ram_rd_data <= addr_ok(ram_rd_addr) ? ddram[ram_idx(ram_rd_addr)] : 8'h00;
  end

  assign busy      = (state_q != ST_IDLE);
  assign disp_on   = disp_q;
  assign cursor_on = cur_q;
  assign blink_on  = blk_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_code  = cmd_code_q;
  assign err       = err_q;

`ifdef LCD1602_READ_EN
  assign lcd_db_oe  = e_s2 & rw_s2;
  assign lcd_db_out = !lcd_db_oe ? 8'h00 :
                      rs_s2      ? ddram[ram_idx(ac_q)] : {busy, ac_q};
`else
  assign lcd_db_oe  = 1'b0;
  assign lcd_db_out = 8'h00;
`endif

  // Entry-mode shift and function-set bits are stored but have no visible effect.
  logic unused_cfg;
  assign unused_cfg = ^{sh_q, func_q};

endmodule

// File: doc/lcd1602_responder.md
LCD1602_RESPONDER -- requirements
Module: lcd1602_responder

Interface
REQ-001 Parameter BUSY_CYCLES, default 2000, Clk cycles busy after a normal instruction or data write (40 us at 50 MHz).
REQ-002 Parameter CLEAR_CYCLES, default 82000, Clk cycles busy after clear-display or return-home (1.64 ms at 50 MHz).
REQ-003 Ports, in this order:
- Clk  in  1  sole clock.
- Rst  in  1  asynchronous, active-high reset.
- lcd_rs  in  1  register select: 0 instruction, 1 data.
- lcd_rw  in  1  0 write, 1 read.
- lcd_e  in  1  enable strobe, asynchronous to Clk.
- lcd_db_in  in  8  bus value driven by the host.
- lcd_db_out  out  8  bus value driven by the responder during reads.
- lcd_db_oe  out  1  output enable for lcd_db_out.
- ram_rd_addr  in  7  debug DDRAM read address.
- ram_rd_data  out  8  DDRAM[ram_rd_addr], registered, 1-cycle latency.
- disp_on, cursor_on, blink_on  out  1 each  display-control bits D, C, B.
- busy  out  1  busy flag BF.
- cmd_valid  out  1  single-cycle pulse when an instruction is accepted.
- cmd_code  out  8  last accepted instruction byte.
- err  out  1  single-cycle pulse on a rejected access.

Function
REQ-004 lcd_e, lcd_rs, lcd_rw and lcd_db_in shall each pass through a 2-flop synchronizer; a falling edge of the synchronized E is the strobe.
REQ-005 The strobe shall act on RS, RW and DB sampled by the synchronized path in the same cycle; state updates occur 1 cycle after the strobe (3 Clk after the raw E fall).
REQ-006 The address counter AC shall be 7 bits. Valid DDRAM addresses: 0x00-0x27 and 0x40-0x67, stored in an 80-byte array.
REQ-007 AC increment shall wrap 0x27 to 0x40 and 0x67 to 0x00; decrement shall wrap 0x40 to 0x27 and 0x00 to 0x67.
REQ-008 Instructions (RS=0, RW=0) shall decode on the highest set bit:
- 0x01 clear: fill all 80 bytes with 0x20, one byte per cycle; AC=0; I/D=1.
- 0x02/0x03 home: AC=0.
- 0x04-07 entry mode: store I/D=bit1 and S=bit0.
- 0x08-0F: D, C, B = bits 2..0.
- 0x10-1F: if S/C=0, move AC by R/L (bit2=1 increments, using REQ-007 wrap); if S/C=1, no change.
- 0x20-3F function set: stored, no other effect.
- 0x40-7F set CGRAM address: enter CGRAM mode.
- 0x80-FF: AC=DB[6:0] and leave CGRAM mode; an invalid address pulses err and leaves AC unchanged.
REQ-009 Data write (RS=1, RW=0): DDRAM[AC]=DB, then AC steps per I/D. In CGRAM mode the write is discarded, AC is unchanged, and err is not pulsed.
REQ-010 State machine: IDLE, FILL, BUSY.
- IDLE -> FILL on a clear instruction.
- IDLE -> BUSY on any other accepted write.
- FILL -> BUSY after address 0x67 is written.
- BUSY -> IDLE when the busy counter reaches 0.
- Counter load: CLEAR_CYCLES-80 on entry to BUSY from FILL; CLEAR_CYCLES for home; BUSY_CYCLES otherwise.
REQ-011 busy shall be 1 in FILL and BUSY. A write strobe outside IDLE shall be ignored and shall pulse err.
REQ-012 cmd_valid shall pulse and cmd_code shall update only for accepted instructions.
REQ-013 Instruction read (RS=0, RW=1): while synchronized E=1, lcd_db_oe=1 and lcd_db_out={busy,AC}. Permitted in any state; no side effect.
REQ-014 Data read (RS=1, RW=1): lcd_db_out=DDRAM[AC] while E=1; on the strobe AC steps per I/D. Rejected with err when not IDLE.
REQ-015 lcd_db_oe shall be 0 whenever RW=0 or E=0.

Reset
REQ-016 Rst shall force, asynchronously:
- state IDLE, AC=0, I/D=1, S=0, D=C=B=0, CGRAM mode off;
- busy=0, cmd_valid=0, err=0, cmd_code=0x00;
- lcd_db_out=0x00, lcd_db_oe=0, ram_rd_data=0x00, synchronizers 0.
REQ-017 DDRAM contents shall not be reset. Reset during FILL shall abandon the fill and leave partially written contents.

Configuration
REQ-018 Macro LCD1602_READ_EN:
- Defined: REQ-013/REQ-014 are active.
- Undefined: lcd_db_oe and lcd_db_out are constant 0, and read strobes (RW=1) are ignored with no err and no AC change.

Verification
REQ-019 Reset, then instruction 0x0E -> cmd_valid pulse, disp_on=1, cursor_on=1, blink_on=0, busy=1 for exactly BUSY_CYCLES cycles.
REQ-020 Write 0x80+0x27, wait idle, write data 0x41 then 0x42 -> DDRAM[0x27]=0x41, DDRAM[0x40]=0x42, AC=0x41.
REQ-021 Write 0x01 -> busy for CLEAR_CYCLES total; afterwards every valid DDRAM address reads 0x20 and AC=0.
REQ-022 Data write during BUSY -> err pulse, DDRAM and AC unchanged.
REQ-023 With LCD1602_READ_EN defined, instruction read during BUSY after 0xC5 -> lcd_db_oe=1, lcd_db_out=0xC5 (BF=1, AC=0x45).
REQ-024 Instruction 0xB0 (address 0x30) -> err pulse, AC unchanged, busy stays 0.
